// File: rtl/rep_blocos.sv
// rep_blocos: nearest-neighbour block upscaler streaming an enlarged image.
//   Parameters: LARGURA x ALTURA source image, FATOR integer upscale per axis.
//   clk, rst_n            : clock (rising edge), asynchronous active-low reset
//   wr_en/wr_addr/wr_data : source memory write port (accepted only in IDLE)
//   start, busy, done     : frame request, frame in progress, end-of-frame pulse
//   out_valid/out_ready   : output handshake
//   out_data/out_x/out_y  : output pixel value and coordinates
//   out_last              : final pixel of the frame
module rep_blocos #(
    parameter int LARGURA = 2,
    parameter int ALTURA  = 2,
    parameter int FATOR   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic [10:0] wr_addr,
    input  logic [7:0]  wr_data,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic [10:0] out_x,
    output logic [10:0] out_y,
    output logic        out_last
);
    localparam int NEW_LARG   = LARGURA * FATOR;
    localparam int NEW_ALTURA = ALTURA * FATOR;
    localparam int N  = LARGURA * ALTURA;
    localparam int AW = N > 1 ? $clog2(N) : 1;
    localparam logic [10:0] XM = 11'(NEW_LARG - 1);
    localparam logic [10:0] YM = 11'(NEW_ALTURA - 1);
    localparam logic [10:0] FM = 11'(FATOR - 1);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
    state_t state, nxt;

    logic [7:0]  mem [N];
    logic [10:0] x, y, col, row, dj, di;
    logic [AW-1:0] addr;
    logic xfer, fim_linha, fim;

    assign out_valid = state == RUN;
    assign busy      = state == RUN;
    assign done      = state == FIN;
    assign xfer      = out_valid & out_ready;
    assign fim_linha = x == XM;
    assign fim       = fim_linha && y == YM;
    assign out_x     = x;
    assign out_y     = y;
    assign out_last  = out_valid & fim;
    // Source address comes from the source row/column counters; only a
    // constant-width multiply, no division of the output coordinates.
    assign addr      = AW'(32'(row) * LARGURA + 32'(col));
    // Memory is only written in IDLE, so a combinational read stays stable
    // for the whole frame, including stalled beats.
    assign out_data  = out_valid ? mem[addr] : 8'd0;

    always_ff @(posedge clk) begin
        if (wr_en && state == IDLE && 32'(wr_addr) < N)
            mem[wr_addr[AW-1:0]] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= nxt;
    end

    always_comb begin
        nxt = state;
        nxt = state == IDLE ? (start ? RUN : IDLE) :
              state == RUN  ? (xfer && fim ? FIN : RUN) : IDLE;
    end

    // dj/di count repetitions of the current source pixel/row; they carry
    // into col/row when they wrap at FATOR-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x <= '0; y <= '0; col <= '0; row <= '0; dj <= '0; di <= '0;
        end else if (xfer) begin
            if (fim) begin
                x <= '0; y <= '0; col <= '0; row <= '0; dj <= '0; di <= '0;
            end else if (fim_linha) begin
                x   <= '0;
                col <= '0;
                dj  <= '0;
                y   <= y + 11'd1;
                di  <= di == FM ? 11'd0 : di + 11'd1;
                row <= di == FM ? row + 11'd1 : row;
            end else begin
                x   <= x + 11'd1;
                dj  <= dj == FM ? 11'd0 : dj + 11'd1;
                col <= dj == FM ? col + 11'd1 : col;
            end
        end
    end
endmodule

// File: tb/tb_rep_blocos.sv
// tb_rep_blocos: directed self-checking bench for rep_blocos (2x2, FATOR 2 and 1).
module tb_rep_blocos;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0, start = 1'b0, out_ready = 1'b1;
    logic [10:0] wr_addr = '0;
    logic [7:0]  wr_data = '0;
    logic        busy, done, out_valid, out_last;
    logic [7:0]  out_data;
    logic [10:0] out_x, out_y;

    logic        wr_en2 = 1'b0, start2 = 1'b0;
    logic [10:0] wr_addr2 = '0;
    logic [7:0]  wr_data2 = '0;
    logic        busy2, done2, out_valid2, out_last2;
    logic [7:0]  out_data2;
    logic [10:0] out_x2, out_y2;

    int checks = 0, failures = 0;
    int bd[16], bx[16], by[16], bl[16];
    int sd[3], sx[3], sy[3];
    int m[4];

    always #5 clk = ~clk;

    rep_blocos dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .busy(busy), .done(done), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_x(out_x), .out_y(out_y), .out_last(out_last)
    );

    rep_blocos #(.LARGURA(2), .ALTURA(2), .FATOR(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2),
        .start(start2), .busy(busy2), .done(done2), .out_valid(out_valid2), .out_ready(1'b1),
        .out_data(out_data2), .out_x(out_x2), .out_y(out_y2), .out_last(out_last2)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic wr(input int a, input int d);
        wr_en = 1'b1; wr_addr = 11'(a); wr_data = 8'(d);
        @(posedge clk) #1;
        wr_en = 1'b0;
    endtask

    task automatic run_frame(input int stall_at, input int stall_len, input int wr_at,
                             input int st_at, output int n, output int dones, output int gap);
        int stalled, last_c, done_c, post;
        n = 0; dones = 0; stalled = 0; last_c = -100; done_c = -200; post = 0;
        out_ready = 1'b1;
        start = 1'b1;
        @(posedge clk) #1;
        start = 1'b0;
        for (int c = 0; c < 100 && post < 4; c++) begin
            wr_en = c == wr_at; wr_addr = '0; wr_data = 8'd99;
            start = c == st_at;
            if (done) begin dones++; done_c = c; end
            if (dones > 0) post++;
            if (out_valid) begin
                if (n == stall_at && stalled < stall_len) begin
                    out_ready = 1'b0;
                    sd[stalled] = out_data; sx[stalled] = out_x; sy[stalled] = out_y;
                    stalled++;
                end else begin
                    out_ready = 1'b1;
                    if (n < 16) begin
                        bd[n] = out_data; bx[n] = out_x; by[n] = out_y; bl[n] = out_last;
                    end
                    if (out_last) last_c = c;
                    n++;
                end
            end else out_ready = 1'b1;
            @(posedge clk) #1;
        end
        wr_en = 1'b0; start = 1'b0; out_ready = 1'b1;
        gap = done_c - last_c;
    endtask

    task automatic check_frame(input string tag, input int n);
        check({tag, "_beats"}, n, 16);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("%s_data%0d", tag, i), bd[i], m[(i / 8) * 2 + (i % 4) / 2]);
            check($sformatf("%s_x%0d", tag, i), bx[i], i % 4);
            check($sformatf("%s_y%0d", tag, i), by[i], i / 4);
            check($sformatf("%s_last%0d", tag, i), bl[i], i == 15 ? 1 : 0);
        end
    endtask

    initial begin
        int n, dones, gap, dn, n2, last2;
        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", out_valid, 0);
        check("rst_last", out_last, 0);
        check("rst_data", out_data, 0);
        check("rst_x", out_x, 0);
        check("rst_y", out_y, 0);
        @(posedge clk) #1;
        rst_n = 1'b1;
        @(posedge clk) #1;

        m = '{10, 20, 30, 40};
        for (int i = 0; i < 4; i++) wr(i, m[i]);

        // basic frame
        run_frame(-1, 0, -1, -1, n, dones, gap);
        check_frame("basic", n);
        check("basic_dones", dones, 1);
        check("basic_done_gap", gap, 1);
        check("basic_busy_after", busy, 0);

        // backpressure at beat 5
        run_frame(4, 3, -1, -1, n, dones, gap);
        check_frame("bp", n);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("bp_hold_data%0d", i), sd[i], 10);
            check($sformatf("bp_hold_x%0d", i), sx[i], 0);
            check($sformatf("bp_hold_y%0d", i), sy[i], 1);
        end
        check("bp_dones", dones, 1);

        // mid-frame reset after 6 transfers
        out_ready = 1'b1;
        start = 1'b1;
        @(posedge clk) #1;
        start = 1'b0;
        repeat (6) @(posedge clk) #1;
        check("mr_pre_x", out_x, 2);
        check("mr_pre_y", out_y, 1);
        rst_n = 1'b0;
        #1;
        check("mr_valid", out_valid, 0);
        check("mr_busy", busy, 0);
        check("mr_x", out_x, 0);
        @(posedge clk) #1;
        rst_n = 1'b1;
        dn = 0;
        for (int c = 0; c < 4; c++) begin
            dn += done;
            @(posedge clk) #1;
        end
        check("mr_no_done", dn, 0);
        run_frame(-1, 0, -1, -1, n, dones, gap);
        check_frame("mr_redo", n);

        // write during RUN is ignored
        run_frame(-1, 0, 2, -1, n, dones, gap);
        check_frame("wrun", n);
        wr(0, 99);
        m[0] = 99;
        run_frame(-1, 0, -1, -1, n, dones, gap);
        check_frame("widle", n);
        wr(0, 10);
        m[0] = 10;

        // start during RUN ignored; out-of-range write ignored
        wr(4, 77);
        run_frame(-1, 0, -1, 3, n, dones, gap);
        check_frame("edge", n);
        check("edge_dones", dones, 1);
        check("edge_busy_after", busy, 0);

        // FATOR=1 identity copy
        for (int i = 0; i < 4; i++) begin
            wr_en2 = 1'b1; wr_addr2 = 11'(i); wr_data2 = 8'(i + 1);
            @(posedge clk) #1;
        end
        wr_en2 = 1'b0;
        start2 = 1'b1;
        @(posedge clk) #1;
        start2 = 1'b0;
        n2 = 0; last2 = -1;
        for (int c = 0; c < 20; c++) begin
            if (out_valid2) begin
                if (n2 < 4) check($sformatf("f1_data%0d", n2), out_data2, n2 + 1);
                if (out_last2) last2 = n2;
                n2++;
            end
            @(posedge clk) #1;
        end
        check("f1_beats", n2, 4);
        check("f1_last_idx", last2, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rep_blocos.md
REP_BLOCOS -- requirements
Module: rep_blocos

Interface
REQ-001 SHALL have parameter LARGURA, default 2: source image width in pixels.
REQ-002 SHALL have parameter ALTURA, default 2: source image height in pixels.
REQ-003 SHALL have parameter FATOR, default 2: integer upscale factor per axis, 1 or greater.
REQ-004 SHALL have derived parameters NEW_LARG = LARGURA*FATOR and NEW_ALTURA = ALTURA*FATOR: output image dimensions.
REQ-005 SHALL have port clk  in  1: single clock, rising edge.
REQ-006 SHALL have port rst_n  in  1: reset, asynchronous, active-low.
REQ-007 SHALL have port wr_en  in  1: source-memory write strobe.
REQ-008 SHALL have port wr_addr  in  11: source pixel address, row-major (linha*LARGURA + coluna).
REQ-009 SHALL have port wr_data  in  8: source pixel value.
REQ-010 SHALL have port start  in  1: request to begin one output frame.
REQ-011 SHALL have port busy  out  1: a frame is in progress.
REQ-012 SHALL have port done  out  1: one-cycle pulse after the frame completes.
REQ-013 SHALL have port out_valid  out  1: out_data, out_x, out_y and out_last are valid.
REQ-014 SHALL have port out_ready  in  1: sink accepts the current beat.
REQ-015 SHALL have port out_data  out  8: output pixel value.
REQ-016 SHALL have ports out_x and out_y  out  11 each: output pixel column and row.
REQ-017 SHALL have port out_last  out  1: marks the final pixel of the frame.

Function
REQ-018 SHALL hold the source image in an internal LARGURA*ALTURA x 8-bit memory.
REQ-019 SHALL write wr_data to memory[wr_addr] on a clk edge only when all of these hold: wr_en=1, FSM in IDLE, wr_addr < LARGURA*ALTURA; all other writes are ignored.
REQ-020 SHALL use an FSM with states IDLE, RUN and FIN; the reset state is IDLE.
REQ-021 SHALL move IDLE->RUN when start=1; the first beat is presented with out_valid=1 on the next cycle (latency 1).
REQ-022 SHALL ignore start while in RUN or FIN.
REQ-023 SHALL emit NEW_LARG*NEW_ALTURA beats in raster order: out_x advances fastest from 0 to NEW_LARG-1, then out_y increments.
REQ-024 SHALL make each beat satisfy out_data = memory[(out_y/FATOR)*LARGURA + out_x/FATOR].
REQ-025 SHALL generate addresses without dividers: source column and row counters plus sub-block counters dj and di, each wrapping at FATOR-1.
REQ-026 SHALL treat a beat as transferred when out_valid=1 and out_ready=1.
REQ-027 SHALL hold out_data, out_x, out_y and out_last stable while out_valid=1 and out_ready=0.
REQ-028 SHALL present the next beat in the cycle immediately after a transfer, with no bubble.
REQ-029 SHALL assert out_last only on the beat with out_x=NEW_LARG-1 and out_y=NEW_ALTURA-1.
REQ-030 SHALL move RUN->FIN on the out_last transfer: out_valid=0 in FIN, done=1 for exactly one cycle, then FIN->IDLE.
REQ-031 SHALL drive busy=1 exactly while the FSM is in RUN.
REQ-032 SHALL behave as an identity copy when FATOR=1.
REQ-033 SHALL drive out_valid=0 in IDLE and FIN; out_data, out_x and out_y are don't-care when out_valid=0.

Reset
REQ-034 SHALL, while rst_n=0 and independent of clk, force the FSM to IDLE; busy, done, out_valid and out_last to 0; out_data, out_x, out_y and all counters to 0.
REQ-035 SHALL abort a frame in progress on reset, with no done pulse.
REQ-036 SHALL NOT clear or alter memory contents on reset.

Verification
REQ-037 SHALL pass the basic frame test (defaults, memory {10,20,30,40}, out_ready=1, start pulse): out_data sequence 10,10,20,20,10,10,20,20,30,30,40,40,30,30,40,40; out_last on beat 16 (x=3,y=3); done pulse on the next cycle; busy=0 afterwards.
REQ-038 SHALL pass the backpressure test (same frame, out_ready=0 for 3 cycles at beat 5): out_data=10, out_x=0, out_y=1 held for all 3 cycles; no beats lost or duplicated; total of 16 transfers.
REQ-039 SHALL pass the mid-frame reset test (rst_n=0 after 6 transfers): out_valid=0 and busy=0 immediately; no done pulse; a new start reproduces the full 16-beat sequence beginning with 10.
REQ-040 SHALL pass the write-during-RUN test (wr_en with addr 0 and data 99 during RUN): current frame unchanged; the same write in IDLE makes the next frame begin 99,99,20,20.
REQ-041 SHALL pass the start/address edge-case test: start during RUN has no effect, giving exactly one done pulse; a write to wr_addr=4 with defaults is ignored and the memory is unchanged.
REQ-042 SHALL pass the FATOR=1 test (LARGURA=2, ALTURA=2, memory {1,2,3,4}): exactly 4 beats, values 1,2,3,4, out_last on the 4th.
